// File: rtl/ahb3_arb_pkg.sv
// Shared types and AHB3-Lite encodings for the round-robin AHB3 arbiter.
package ahb3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } arb_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DFLT    = 4'b0011;

endpackage

// File: rtl/ahb3_rr_picker.sv
// Combinational round-robin picker: first requester strictly after 'last', cyclically.
module ahb3_rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   enc;
  int              sum;

  // rot[k] is the request of the requester k+1 positions after 'last'
  always_comb begin
    rot   = '0;
    cand  = last;
    enc   = '0;
    sum   = 0;
    valid = |req;
    for (int k = 0; k < NREQ; k++) begin
      cand   = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
      rot[k] = req[cand];
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) enc = IW'(k);
    end
    sum = int'(last) + 1 + int'(enc);
    if (sum >= NREQ) sum = sum - NREQ;
    idx = IW'(sum);
  end

endmodule

// File: rtl/ahb3_arbiter.sv
// Round-robin sequencer sharing one AHB3-Lite slave among NREQ requesters.
// Optional `AHB3_ARB_LOCK_EN adds a lock input that re-grants the owner and drives hmastlock.
module ahb3_arbiter
  import ahb3_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                    hclk,
  input  logic                    hrst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         we,
  input  logic [NREQ*AW-1:0]      addr,
  input  logic [NREQ*DW-1:0]      wdata,
`ifdef AHB3_ARB_LOCK_EN
  input  logic [NREQ-1:0]         lock,
`endif
  output logic [NREQ-1:0]         ack,
  output logic [DW-1:0]           rdata,
  output logic                    err,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    hsel,
  output logic [AW-1:0]           haddr,
  output logic [DW-1:0]           hwdata,
  output logic                    hwrite,
  output logic [2:0]              hsize,
  output logic [2:0]              hburst,
  output logic [3:0]              hprot,
  output logic [1:0]              htrans,
  output logic                    hmastlock,
  output logic                    hready,
  input  logic [DW-1:0]           hrdata,
  input  logic                    hreadyout,
  input  logic                    hresp
);

  localparam int IW = $clog2(NREQ);

  arb_state_t    state, state_nx;
  logic [IW-1:0] last;
  logic [IW-1:0] pick_id;
  logic [IW-1:0] sel_id;
  logic          pick_valid;
  logic [DW-1:0] lat_wdata;
  logic [AW-1:0] addr_arr  [NREQ];
  logic [DW-1:0] wdata_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i]  = addr[i*AW +: AW];
      wdata_arr[i] = wdata[i*DW +: DW];
    end
  end

  ahb3_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_id)
  );

  assign hsize  = HSIZE_WORD;
  assign hburst = HBURST_SINGLE;
  assign hprot  = HPROT_DFLT;
  assign hready = 1'b1;

`ifdef AHB3_ARB_LOCK_EN
  logic lock_hold;

  // A locked owner that still requests skips the rotation for one grant
  assign sel_id = (lock_hold && req[gnt_id]) ? gnt_id : pick_id;

  always_ff @(posedge hclk) begin
    if (hrst) begin
      lock_hold <= 1'b0;
      hmastlock <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          hmastlock <= lock[sel_id];
          lock_hold <= 1'b0;
        end
        DATA: if (hreadyout) hmastlock <= 1'b0;
        RESP: lock_hold <= lock[gnt_id];
        default: ;
      endcase
    end
  end
`else
  assign sel_id    = pick_id;
  assign hmastlock = 1'b0;
`endif

  always_ff @(posedge hclk) begin
    if (hrst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_valid) state_nx = ADDR;
      ADDR:    state_nx = DATA;
      DATA:    if (hreadyout) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs are registered so each phase lines up with the state it belongs to
  always_ff @(posedge hclk) begin
    if (hrst) begin
      hsel      <= 1'b0;
      htrans    <= HTRANS_IDLE;
      haddr     <= '0;
      hwdata    <= '0;
      hwrite    <= 1'b0;
      ack       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      gnt_id    <= '0;
      last      <= IW'(NREQ - 1);
      lat_wdata <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: if (pick_valid) begin
          gnt_id    <= sel_id;
          haddr     <= addr_arr[sel_id];
          hwrite    <= we[sel_id];
          lat_wdata <= wdata_arr[sel_id];
          hsel      <= 1'b1;
          htrans    <= HTRANS_NONSEQ;
        end
        ADDR: begin
          htrans <= HTRANS_IDLE;
          hwdata <= lat_wdata;
        end
        DATA: if (hreadyout) begin
          hsel        <= 1'b0;
          rdata       <= hrdata;
          err         <= hresp;
          ack[gnt_id] <= 1'b1;
        end
        RESP: last <= gnt_id;
        default: ;
      endcase
    end
  end

endmodule
